// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Results are held pending and only commit to HI/LO on completion.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       XALUOp,
  input  logic             Start,
  input  logic             rollback,
  output logic [WIDTH-1:0] XALU_Out,
  output logic             Busy,
  output logic             Done
);

  localparam int W2   = 2 * WIDTH;
  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [CW-1:0] MUL_C = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_C = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  logic op_mul, op_div, op_sgn, op_acc, op_sub;
  logic op_mthi, op_mtlo;

  logic [W2-1:0]    a_ext, b_ext, prod, acc;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_div;
  logic [WIDTH-1:0] q_mag, r_mag, quo, rem;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // Decode the opcode into operation class flags
  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_acc  = 1'b0;
    op_sub  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (XALUOp)
      4'd0: begin op_mul = 1'b1; op_sgn = 1'b1; end
      4'd1: op_mul = 1'b1;
      4'd2: begin op_div = 1'b1; op_sgn = 1'b1; end
      4'd3: op_div = 1'b1;
      4'd6: op_mthi = 1'b1;
      4'd7: op_mtlo = 1'b1;
      4'd8: begin
        op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1;
      end
      4'd9: begin op_mul = 1'b1; op_acc = 1'b1; end
      4'd10: begin
        op_mul = 1'b1; op_acc = 1'b1;
        op_sub = 1'b1; op_sgn = 1'b1;
      end
      4'd11: begin
        op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // Compute the pending result from the operands and current HI/LO
  always_comb begin
    a_ext = op_sgn ? {{WIDTH{D1[WIDTH-1]}}, D1}
                   : {{WIDTH{1'b0}}, D1};
    b_ext = op_sgn ? {{WIDTH{D2[WIDTH-1]}}, D2}
                   : {{WIDTH{1'b0}}, D2};
    prod  = a_ext * b_ext;
    acc   = op_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);

    // Signed divide via magnitudes; MIN/-1 falls out as MIN, rem 0
    a_neg = op_sgn & D1[WIDTH-1];
    b_neg = op_sgn & D2[WIDTH-1];
    a_mag = a_neg ? -D1 : D1;
    b_mag = b_neg ? -D2 : D2;
    b_div = (D2 == '0) ? WIDTH'(1) : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    {nxt_hi, nxt_lo} = {hi, lo};
    if (op_div) begin
      if (D2 != '0) {nxt_hi, nxt_lo} = {rem, quo};
    end else if (op_acc) begin
      {nxt_hi, nxt_lo} = acc;
    end else if (op_mul) begin
      {nxt_hi, nxt_lo} = prod;
    end
  end

  // Controller: issue, count down, commit or abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start && !rollback) begin
            if (op_mul || op_div) begin
              res_hi <= nxt_hi;
              res_lo <= nxt_lo;
              cnt    <= op_div ? DIV_C : MUL_C;
              state  <= RUN;
            end else if (op_mthi) begin
              hi <= D1;
            end else if (op_mtlo) begin
              lo <= D1;
            end
          end
        end
        RUN: begin
          if (rollback) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            Done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == RUN);

  // Move-from-HI/LO read port
  always_comb begin
    unique case (XALUOp)
      4'd4:    XALU_Out = hi;
      4'd5:    XALU_Out = lo;
      default: XALU_Out = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Two instances: default 32-bit and a 16-bit short-latency one.
module tb_muldiv_unit;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } rd_t;

  typedef struct {
    string nm;
    int    len;
    logic  done;
  } run_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d1, d2;
  logic [3:0]  op;
  logic        start, start_b, rb;
  logic [31:0] out;
  logic [15:0] out_b;
  logic        busy, done, busy_b, done_b;
  logic        rd_en, rd_sel;

  int total = 0;
  int pass  = 0;
  int blen  = 0;
  int blen_b = 0;

  rd_t  exp_rd[$];
  run_t exp_run[$];
  run_t exp_run_b[$];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .D1(d1), .D2(d2),
    .XALUOp(op), .Start(start), .rollback(rb),
    .XALU_Out(out), .Busy(busy), .Done(done)
  );

  muldiv_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .D1(d1[15:0]), .D2(d2[15:0]),
    .XALUOp(op), .Start(start_b), .rollback(rb),
    .XALU_Out(out_b), .Busy(busy_b), .Done(done_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  // Read-port monitor
  always @(negedge clk) begin
    rd_t e;
    if (rd_en) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 32'(exp_rd.size()), 32'd1);
      end else begin
        e = exp_rd.pop_front();
        chk(e.nm, rd_sel ? {16'h0, out_b} : out, e.v);
      end
    end
  end

  // Busy/Done monitor for the 32-bit instance
  always @(negedge clk) begin
    run_t r;
    if (busy) begin
      blen++;
    end else if (blen > 0) begin
      if (exp_run.size() == 0) begin
        chk("unexpected_busy", 32'(blen), 32'd0);
      end else begin
        r = exp_run.pop_front();
        chk({r.nm, "_busy_len"}, 32'(blen), 32'(r.len));
        chk({r.nm, "_done"}, {31'h0, done}, {31'h0, r.done});
      end
      blen = 0;
    end else if (done) begin
      chk("spurious_done", {31'h0, done}, 32'd0);
    end
  end

  // Busy/Done monitor for the 16-bit instance
  always @(negedge clk) begin
    run_t r;
    if (busy_b) begin
      blen_b++;
    end else if (blen_b > 0) begin
      if (exp_run_b.size() == 0) begin
        chk("b_unexpected_busy", 32'(blen_b), 32'd0);
      end else begin
        r = exp_run_b.pop_front();
        chk({r.nm, "_busy_len"}, 32'(blen_b), 32'(r.len));
        chk({r.nm, "_done"}, {31'h0, done_b}, {31'h0, r.done});
      end
      blen_b = 0;
    end else if (done_b) begin
      chk("b_spurious_done", {31'h0, done_b}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(bit w, logic [3:0] o,
                     logic [31:0] a, logic [31:0] b, bit r);
    d1 = a;
    d2 = b;
    op = o;
    rb = r;
    if (w) start_b = 1'b1;
    else   start   = 1'b1;
    tick();
    start   = 1'b0;
    start_b = 1'b0;
    rb      = 1'b0;
    op      = 4'd15;
  endtask

  task automatic expect_run(bit w, string nm, int len, logic dn);
    if (w) exp_run_b.push_back('{nm, len, dn});
    else   exp_run.push_back('{nm, len, dn});
  endtask

  task automatic wait_idle(bit w, string nm);
    for (int i = 0; i < 200 && (w ? busy_b : busy); i++) tick();
    chk({nm, "_timeout"}, {31'h0, w ? busy_b : busy}, 32'd0);
  endtask

  task automatic rd(bit w, logic [31:0] h, logic [31:0] l,
                    string nm);
    rd_sel = w;
    rd_en  = 1'b1;
    op     = 4'd4;
    exp_rd.push_back('{{nm, "_hi"}, h});
    tick();
    op = 4'd5;
    exp_rd.push_back('{{nm, "_lo"}, l});
    tick();
    rd_en = 1'b0;
    op    = 4'd15;
  endtask

  task automatic run_op(bit w, string nm, logic [3:0] o,
                        logic [31:0] a, logic [31:0] b, int len);
    expect_run(w, nm, len, 1'b1);
    iss(w, o, a, b, 1'b0);
    wait_idle(w, nm);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start_b = 1'b0;
    rb      = 1'b0;
    rd_en   = 1'b0;
    rd_sel  = 1'b0;
    op      = 4'd15;
    d1      = '0;
    d2      = '0;
    tick();
    tick();
    reset = 1'b0;
    rd(0, 32'h0, 32'h0, "reset");
    rd(1, 32'h0, 32'h0, "reset_b");

    run_op(0, "mult", 4'd0, 32'hFFFF_FFFD, 32'd7, 5);
    rd(0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");

    run_op(0, "div", 4'd2, 32'hFFFF_FFF9, 32'd2, 10);
    rd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");

    run_op(0, "divu0", 4'd3, 32'd7, 32'd0, 10);
    rd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu0");

    iss(0, 4'd6, 32'h1, 32'h0, 1'b0);
    iss(0, 4'd7, 32'hFFFF_FFFF, 32'h0, 1'b0);
    rd(0, 32'h1, 32'hFFFF_FFFF, "mthlo");

    run_op(0, "maddu", 4'd9, 32'd1, 32'd1, 5);
    rd(0, 32'h2, 32'h0, "maddu");

    run_op(0, "msub", 4'd10, 32'd1, 32'd1, 5);
    rd(0, 32'h1, 32'hFFFF_FFFF, "msub");

    // rollback during the third busy cycle
    expect_run(0, "rb3", 3, 1'b0);
    iss(0, 4'd0, 32'd5, 32'd5, 1'b0);
    tick();
    tick();
    rb = 1'b1;
    tick();
    rb = 1'b0;
    rd(0, 32'h1, 32'hFFFF_FFFF, "rb3");

    // rollback in the last busy cycle
    expect_run(0, "rblast", 5, 1'b0);
    iss(0, 4'd0, 32'd5, 32'd5, 1'b0);
    repeat (4) tick();
    rb = 1'b1;
    tick();
    rb = 1'b0;
    rd(0, 32'h1, 32'hFFFF_FFFF, "rblast");

    // start together with rollback is discarded
    iss(0, 4'd0, 32'd5, 32'd5, 1'b1);
    tick();
    rd(0, 32'h1, 32'hFFFF_FFFF, "startrb");

    // back-to-back: MADDU issued in the Done cycle
    run_op(0, "b2b_mult", 4'd1, 32'd2, 32'd3, 5);
    run_op(0, "b2b_madd", 4'd9, 32'd1, 32'd1, 5);
    rd(0, 32'h0, 32'h7, "b2b");

    // start and reset at the same edge
    d1    = 32'd9;
    d2    = 32'd9;
    op    = 4'd0;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    op    = 4'd15;
    tick();
    rd(0, 32'h0, 32'h0, "start_reset");

    // reset in the middle of a run
    iss(0, 4'd6, 32'h5, 32'h0, 1'b0);
    expect_run(0, "rst_mid", 3, 1'b0);
    iss(0, 4'd0, 32'd3, 32'd3, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(0, 32'h0, 32'h0, "rst_mid");

    // 16-bit instance
    run_op(1, "b_multu", 4'd1, 32'hFFFF, 32'hFFFF, 1);
    rd(1, 32'hFFFE, 32'h0001, "b_multu");

    run_op(1, "b_div", 4'd2, 32'h8000, 32'hFFFF, 3);
    rd(1, 32'h0, 32'h8000, "b_div");

    repeat (3) tick();
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("run_queue_empty", 32'(exp_run.size()), 32'd0);
    chk("run_b_queue_empty", 32'(exp_run_b.size()), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage. It is the successor to the fixed 32-bit XALU: width and multiply/divide latencies are parameters, multiply-accumulate/subtract modes are added, and a Done pulse is produced. Results commit to HI/LO only on completion, so a rollback always leaves architectural state clean. The hazard unit stalls MF*/MT*/multi-cycle instructions in D while `Busy` is high.

## Interface
- `WIDTH`, 32, operand/HI/LO width (≥8)
- `MUL_LAT`, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (≥1)
- `DIV_LAT`, 10, busy cycles for DIV/DIVU (≥1)

- `clk` in 1 — single clock; all state updates on rising edge
- `reset` in 1 — synchronous, active-high
- `D1` in WIDTH — operand A (rs)
- `D2` in WIDTH — operand B (rt)
- `XALUOp` in 4 — 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; 12–15 no-op
- `Start` in 1 — issue strobe, sampled at the rising edge
- `rollback` in 1 — cancels the current issue or in-flight op (E-stage instruction flushed by an exception)
- `XALU_Out` out WIDTH — HI when XALUOp=4, LO when XALUOp=5, else 0 (combinational)
- `Busy` out 1 — operation in flight
- `Done` out 1 — one-cycle pulse in the first cycle that committed HI/LO are visible

## Operation
- States: IDLE, RUN. Down-counter `cnt`, pending result regs `res_hi`/`res_lo`.
- IDLE + Start + op∈{0,1,2,3,8–11} + !rollback: latch operands and op, compute the pending result, `cnt`←LAT−1, go to RUN.
- IDLE + Start + MTHI/MTLO + !rollback: HI (or LO) ← D1 at that edge. No Busy. No Done.
- MFHI/MFLO: no state change. `Start` is irrelevant.
- RUN: decrement `cnt` each edge. At the edge where `cnt`=0 and !rollback: HI←res_hi, LO←res_lo, go to IDLE, Done=1 for the next cycle.
- RUN + rollback at any edge: go to IDLE. HI/LO are unchanged and Done stays 0.
- Start while in RUN is ignored; the controller never does this.
- Start and rollback asserted at the same edge: the issue is discarded.
- MULT/MULTU: {HI,LO} = signed/unsigned 2·WIDTH product.
- MADD(U)/MSUB(U): {HI,LO} = {HI,LO} ± product, using HI/LO as sampled at issue. Wraps mod 2^(2·WIDTH).
- DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Signed MIN/−1: LO = MIN, HI = 0.
- Divide by zero: HI/LO unchanged. The op still takes the full DIV_LAT busy cycles.
- Reset: HI=0, LO=0, state IDLE, cnt=0, Busy=0, Done=0, pending regs=0. Reset overrides Start and rollback and aborts RUN.

## Timing
- Issue at edge t (RUN op, latency L): Busy=1 in cycles t+1 … t+L.
- HI/LO are written at the edge ending cycle t+L.
- In cycle t+L+1: Busy=0, Done=1, and MFHI/MFLO return the new value.
- MTHI/MTLO at edge t: the new value is readable in cycle t+1.
- Busy is a registered output (state==RUN). Done is registered.
- XALU_Out is combinational from XALUOp and the HI/LO registers only.
- Back-to-back: a new Start is accepted in the Done cycle (t+L+1). An issued MADD then sees the committed HI/LO.
- Rollback asserted in cycle t+L (last busy cycle): the op is aborted and HI/LO are unchanged.

## Test plan
- Reset, then MULT D1=−3 (0xFFFFFFFD), D2=7, MUL_LAT=5 → Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done single pulse.
- DIV D1=−7, D2=2, DIV_LAT=10 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7/0 → HI/LO unchanged, Busy still 10 cycles.
- MTHI 0x1, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=0x2, LO=0x0. Then MSUB 1×1 → HI=0x1, LO=0xFFFFFFFF.
- MULT 5×5 with rollback in busy cycle 3 → Busy drops the next cycle, no Done, HI/LO keep prior values. Start together with rollback → no Busy.
- Start and reset asserted at the same edge, and reset mid-RUN → Busy=0, Done=0, HI=LO=0 next cycle.
- Re-parametrise WIDTH=16, MUL_LAT=1, DIV_LAT=3: MULTU 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001 after 1 busy cycle. DIV 0x8000/0xFFFF → LO=0x8000, HI=0.
